// File: rtl/param_data_mem.sv
// param_data_mem: word-addressed data memory with byte enables, fixed access latency,
// out-of-range and conflicting-request error reporting.
module param_data_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   adr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                busy,
  output logic                err
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BYTES-1:0]    be_q, be_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                accept, conflict, commit, oor;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  // The *_d request fields are the live request on the accepting edge, so a
  // zero-latency access can complete on that same edge.
  always_comb begin
    accept   = (state_q == IDLE) && (mem_read ^ mem_write);
    conflict = (state_q == IDLE) && mem_read && mem_write;
    adr_d    = accept ? adr : adr_q;
    wdata_d  = accept ? wdata : wdata_q;
    be_d     = accept ? be : be_q;
    wr_d     = accept ? mem_write : wr_q;
    idx      = adr_d[OFF_W +: IDX_W];
    oor      = {1'b0, adr_d} >= LIMIT;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (LATENCY > 0) ? WAIT : DONE;
        cnt_d   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
      end
      WAIT: begin
        state_d = (cnt_q == 4'd0) ? DONE : WAIT;
        cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    commit  = (state_d == DONE) && (state_q != DONE);
    err_d   = conflict || (commit && oor);
    rdata_d = (commit && !wr_d) ? (oor ? '0 : mem[idx]) : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    adr_q   <= adr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
    wr_q    <= wr_d;
  end

  // Reset takes priority so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (rst && commit && wr_d && !oor)
      for (int i = 0; i < BYTES; i++)
        if (be_d[i]) mem[idx][8*i +: 8] <= wdata_d[8*i +: 8];
  end

  assign rdata = rdata_q;
  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);
  assign err   = err_q;
endmodule

// File: tb/tb_param_data_mem.sv
// tb_param_data_mem: scoreboard bench for param_data_mem, LATENCY=2 and LATENCY=0 builds.
module tb_param_data_mem;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] adr, wdata, rdata, adr0, wdata0, rdata0;
  logic [3:0]  be, be0;
  logic        mem_read, mem_write, ready, busy, err;
  logic        mem_read0, mem_write0, ready0, busy0, err0;

  param_data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) d2 (
    .clk(clk), .rst(rst), .adr(adr), .wdata(wdata), .be(be), .mem_read(mem_read),
    .mem_write(mem_write), .rdata(rdata), .ready(ready), .busy(busy), .err(err));

  param_data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(0)) d0 (
    .clk(clk), .rst(rst), .adr(adr0), .wdata(wdata0), .be(be0), .mem_read(mem_read0),
    .mem_write(mem_write0), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));

  typedef struct {
    int          due;
    logic        rdy;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  exp_t q2[$], q0[$];
  exp_t m2, m0;
  int   cyc = 0;
  int   tests = 0, fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (ready || err)) begin
      if (q2.size() == 0) chk("unexpected_L2", {62'd0, ready, err}, 64'd0);
      else begin
        m2 = q2.pop_front();
        chk("cycle_L2", 64'(cyc), 64'(m2.due));
        chk("ready_L2", 64'(ready), 64'(m2.rdy));
        chk("err_L2", 64'(err), 64'(m2.err));
        if (m2.chk) chk("rdata_L2", 64'(rdata), 64'(m2.data));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && (ready0 || err0)) begin
      if (q0.size() == 0) chk("unexpected_L0", {62'd0, ready0, err0}, 64'd0);
      else begin
        m0 = q0.pop_front();
        chk("cycle_L0", 64'(cyc), 64'(m0.due));
        chk("ready_L0", 64'(ready0), 64'(m0.rdy));
        chk("err_L0", 64'(err0), 64'(m0.err));
        if (m0.chk) chk("rdata_L0", 64'(rdata0), 64'(m0.data));
      end
    end
  end

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; adr = '0; wdata = '0; be = '0;
    mem_read0 = 0; mem_write0 = 0; adr0 = '0; wdata0 = '0; be0 = '0;
  endtask

  // Called just after a rising edge; issues one request and waits for completion.
  task automatic req(input int lat, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, input logic ee,
                     input logic ck, input logic [31:0] xd);
    exp_t e;
    int n;
    e.due = cyc + 1 + ((rd && wr) ? 0 : lat);
    e.rdy = !(rd && wr);
    e.err = ee;
    e.chk = ck;
    e.data = xd;
    if (lat == 0) begin
      mem_read0 = rd; mem_write0 = wr; adr0 = a; wdata0 = d; be0 = b; q0.push_back(e);
    end else begin
      mem_read = rd; mem_write = wr; adr = a; wdata = d; be = b; q2.push_back(e);
    end
    @(posedge clk); #1;
    idle_inputs();
    n = 0;
    while (((lat == 0) ? busy0 : busy) && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_cycles", 64'(n), 64'((rd && wr) ? 0 : lat + 1));
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy_L0", 64'(busy0), 64'd0);
    rst = 1;
    // LATENCY=2: write then read back, accepted on the first edge out of reset
    req(2, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    req(2, 1, 0, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
    req(2, 1, 0, 32'h13, 0, 0, 0, 1, 32'hDEADBEEF);
    // byte enables
    req(2, 0, 1, 32'h20, 32'h11223344, 4'hF, 0, 0, 0);
    req(2, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    chk("rdata_hold_over_write", 64'(rdata), 64'hDEADBEEF);
    req(2, 1, 0, 32'h20, 0, 0, 0, 1, 32'h11BB33DD);
    // out of range: 0x400 aliases word 0 in the low index bits
    req(2, 0, 1, 32'h0, 32'h01020304, 4'hF, 0, 0, 0);
    req(2, 1, 0, 32'h400, 0, 0, 1, 1, 32'h0);
    req(2, 0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
    req(2, 1, 0, 32'h0, 0, 0, 0, 1, 32'h01020304);
    req(2, 1, 0, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
    // simultaneous read and write
    req(2, 1, 1, 32'h10, 32'h0, 4'hF, 1, 0, 0);
    req(2, 1, 0, 32'h10, 0, 0, 0, 1, 32'hDEADBEEF);
    // reset during WAIT aborts a pending write
    req(2, 0, 1, 32'h8, 32'h0, 4'hF, 0, 0, 0);
    req(2, 1, 0, 32'h20, 0, 0, 0, 1, 32'h11BB33DD);
    mem_write = 1; adr = 32'h8; wdata = 32'h55; be = 4'hF;
    @(posedge clk); #1;
    idle_inputs();
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst = 0;
    @(posedge clk); #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(ready), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_rdata", 64'(rdata), 64'd0);
    rst = 1;
    repeat (4) begin @(posedge clk); #1; end
    req(2, 1, 0, 32'h8, 0, 0, 0, 1, 32'h0);
    // LATENCY=0 build
    req(0, 0, 1, 32'h4, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    req(0, 1, 0, 32'h4, 0, 0, 0, 1, 32'hCAFEF00D);
    req(0, 1, 0, 32'h800, 0, 0, 1, 1, 32'h0);
    q0.push_back('{cyc + 1, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D});
    q0.push_back('{cyc + 3, 1'b1, 1'b0, 1'b1, 32'hCAFEF00D});
    mem_read0 = 1; adr0 = 32'h4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_busy_L0", 64'(busy0), 64'(i != 1));
    end
    idle_inputs();
    repeat (4) begin @(posedge clk); #1; end
    chk("queues_drained", 64'(q2.size() + q0.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
